// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR random-value arbiter: LFSR geometry and FSM state type.
package lfsr_pkg;

  localparam int LFSR_W = 10;
  localparam int TAP_HI = 9;
  localparam int TAP_LO = 6;
  localparam logic [LFSR_W-1:0] LOCKUP_STATE = 10'h3FF;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    REFRESH
  } arb_state_e;

endpackage

// File: rtl/lfsr10.sv
// 10-bit XNOR Fibonacci LFSR (taps 9 and 6) with a synchronous parallel load.
module lfsr10
  import lfsr_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [LFSR_W-1:0] load_val,
  output logic [LFSR_W-1:0] q
);

  // All-ones is the XNOR lock-up state, so a load or a stray arrival there is forced to zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (load) begin
      q <= (load_val == LOCKUP_STATE) ? '0 : load_val;
    end else if (q == LOCKUP_STATE) begin
      q <= '0;
    end else begin
      q <= {q[LFSR_W-2:0], ~(q[TAP_HI] ^ q[TAP_LO])};
    end
  end

endmodule

// File: rtl/lfsr_rand_arbiter.sv
// Round-robin arbiter handing out 10-bit LFSR values, one grant per IDLE->GRANT->REFRESH pass.
// Optional seed loading is enabled by defining LFSR_SEED_LOAD_EN.
module lfsr_rand_arbiter
  import lfsr_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ADV_CYCLES = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [LFSR_W-1:0]  rand_out,
  output logic               busy
`ifdef LFSR_SEED_LOAD_EN
  ,
  input  logic               seed_load,
  input  logic [LFSR_W-1:0]  seed
`endif
);

  localparam int PTR_W = 3;

  arb_state_e         state;
  logic [PTR_W-1:0]   rr_ptr;
  logic [3:0]         refresh_cnt;
  logic [LFSR_W-1:0]  lfsr_q;
  logic               lfsr_load;
  logic [LFSR_W-1:0]  lfsr_load_val;

  logic               found;
  logic               hi_found;
  logic [PTR_W-1:0]   hi_win;
  logic [PTR_W-1:0]   lo_win;
  logic [PTR_W-1:0]   winner;
  logic [PTR_W-1:0]   rr_next;

`ifdef LFSR_SEED_LOAD_EN
  assign lfsr_load     = seed_load;
  assign lfsr_load_val = seed;
`else
  assign lfsr_load     = 1'b0;
  assign lfsr_load_val = '0;
`endif

  lfsr10 u_lfsr (
    .clk      (clk),
    .reset    (reset),
    .load     (lfsr_load),
    .load_val (lfsr_load_val),
    .q        (lfsr_q)
  );

  // Lowest request at or above rr_ptr wins; otherwise wrap to the lowest request overall.
  always_comb begin
    hi_found = 1'b0;
    hi_win   = '0;
    lo_win   = '0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (req[j]) begin
        lo_win = PTR_W'(j);
        if (PTR_W'(j) >= rr_ptr) begin
          hi_found = 1'b1;
          hi_win   = PTR_W'(j);
        end
      end
    end
    found   = |req;
    winner  = hi_found ? hi_win : lo_win;
    rr_next = (winner == PTR_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      gnt         <= '0;
      rand_out    <= '0;
      busy        <= 1'b0;
      rr_ptr      <= '0;
      refresh_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            state    <= GRANT;
            gnt      <= NUM_REQ'(1) << winner;
            rand_out <= lfsr_q;
            busy     <= 1'b1;
            rr_ptr   <= rr_next;
          end else begin
            gnt <= '0;
          end
        end
        GRANT: begin
          state       <= REFRESH;
          gnt         <= '0;
          refresh_cnt <= '0;
        end
        REFRESH: begin
          if (refresh_cnt == 4'(ADV_CYCLES - 1)) begin
            state       <= IDLE;
            busy        <= 1'b0;
            refresh_cnt <= '0;
          end else begin
            refresh_cnt <= refresh_cnt + 4'd1;
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/lfsr_rand_arbiter.md
LFSR_RAND_ARBITER -- requirements
Module: lfsr_rand_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters, legal range 2..8.
REQ-002 Parameter ADV_CYCLES, default 1: REFRESH cycles between grants, legal range 1..15.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req  input  NUM_REQ  per-requester random-value request, level; held until granted.
REQ-006 gnt  output  NUM_REQ  one-hot grant pulse, one cycle; rand_out is valid while any bit is set.
REQ-007 rand_out  output  10  random value delivered with gnt; holds its value until the next grant.
REQ-008 busy  output  1  high in GRANT and REFRESH.
REQ-009 seed_load  input  1  load seed into the LFSR; port exists only when the Configuration macro is defined.
REQ-010 seed  input  10  seed value; port exists only when the Configuration macro is defined.

Function
REQ-011 Internal 10-bit LFSR shall step on every cycle outside reset: shift left by one, bit0 <= XNOR(state[9], state[6]).
REQ-012 LFSR state 10'h3FF (XNOR lock-up) shall be replaced by 10'h000 on the next edge instead of stepping.
REQ-013 FSM states shall be IDLE, GRANT and REFRESH.
REQ-014 IDLE with any req bit set at an edge -> GRANT: gnt <= one-hot winner, rand_out <= pre-step LFSR state.
REQ-015 IDLE with req all zero -> stay in IDLE with gnt = 0.
REQ-016 GRANT shall last exactly one cycle, then go to REFRESH, with gnt <= 0.
REQ-017 REFRESH shall last ADV_CYCLES cycles, counted by a 4-bit counter, then go to IDLE; req is ignored during GRANT and REFRESH.
REQ-018 Minimum grant-to-grant spacing shall be 2+ADV_CYCLES cycles.
REQ-019 Arbitration shall be round-robin: search starts at rr_ptr and wraps modulo NUM_REQ.
REQ-020 On each grant, rr_ptr <= (winner+1) mod NUM_REQ; the wrap from NUM_REQ-1 goes to 0.
REQ-021 A requester deasserting req before it is granted shall be legal; it is simply skipped.
REQ-022 req bits at index >= NUM_REQ do not exist; a single requester shall always win regardless of rr_ptr.

Reset
REQ-023 On reset: state = IDLE, LFSR = 10'h000, rand_out = 10'h000, gnt = 0, busy = 0, rr_ptr = 0, REFRESH counter = 0.
REQ-024 Reset asserted during GRANT or REFRESH shall abort the transaction; no gnt pulse shall appear in the cycle after reset.

Configuration
REQ-025 With macro LFSR_SEED_LOAD_EN defined: seed_load high at an edge loads the LFSR with seed (10'h3FF is coerced to 10'h000), overriding the step and taking priority over REQ-012.
REQ-026 seed_load shall not affect the FSM state, gnt or rand_out.
REQ-027 Without LFSR_SEED_LOAD_EN: seed_load and seed ports are absent and the LFSR is only reset or stepped.

Structure
REQ-028 A shared package lfsr_pkg shall hold LFSR_W = 10, tap indices TAP_HI = 9 and TAP_LO = 6, LOCKUP_STATE = 10'h3FF, and the FSM state enum type.
REQ-029 The LFSR shall be a sub-module lfsr10 (clk, reset, load, load_val, q); the arbiter and FSM shall be in lfsr_rand_arbiter.

Verification
REQ-030 Reset, then req=4'b0001 from cycle 0 with ADV_CYCLES=1 -> cycle 1 gnt=0001, rand_out=0x000; cycle 4 gnt=0001, rand_out=0x007.
REQ-031 Free-run from reset with no req -> LFSR sequence 0x001, 0x003, 0x007, ..., 0x03F, 0x07F, 0x0FE; period 1023; 0x3FF never reached.
REQ-032 req=4'b1111 held -> grants 0001, 0010, 0100, 1000, 0001 in order, each spaced 3 cycles apart.
REQ-033 req=4'b1010 with rr_ptr=2 -> gnt=1000, then gnt=0010; req bit 3 dropped before its grant -> bit 3 never granted.
REQ-034 Reset asserted in the GRANT cycle -> next cycle gnt=0, busy=0, rand_out=0x000, state IDLE.
REQ-035 With LFSR_SEED_LOAD_EN: seed=0x155 loaded, then a grant in the next IDLE cycle -> rand_out=0x155; seed=0x3FF loaded -> LFSR=0x000.
